// File: rtl/alu_muldiv_seq_pkg.sv
// rtl/alu_muldiv_seq_pkg.sv - shared codes and state encoding for the RV32M multiply/divide sequencer
package alu_muldiv_seq_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_PASS = 4'b1111;

    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_MULHU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b100;
    localparam logic [2:0] OP_DIVU  = 3'b101;
    localparam logic [2:0] OP_REM   = 3'b110;
    localparam logic [2:0] OP_REMU  = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPEC,
        ST_NEGA,
        ST_NEGB,
        ST_ITER,
        ST_NEGR,
        ST_DONE
    } state_e;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_illegal(input logic [2:0] op);
        return ~op[2] & op[1];
    endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - multi-cycle MUL/MULHU/DIV/DIVU/REM/REMU sequencer borrowing the core ALU
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy,
    output logic [XLEN-1:0] alu_src1,
    output logic [XLEN-1:0] alu_src2,
    output logic [3:0]      alu_func,
    input  logic [XLEN-1:0] alu_out
);

    state_e             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [XLEN-1:0]    a_q, a_d, b_q, b_d;
    logic [XLEN-1:0]    hi_q, hi_d, lo_q, lo_d;
    logic [XLEN-1:0]    res_q, res_d;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [XLEN:0]      s;
    logic               ge;
    logic               op_is_div;

    // hi/lo double as remainder/quotient during division
    assign s         = {hi_q, lo_q[XLEN-1]};
    assign ge        = s[XLEN] | (s[XLEN-1:0] >= b_q);
    assign op_is_div = op_q[2];

    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign out_result = res_q;

    // ALU drive depends only on registered state so alu_out never loops back into it
    always_comb begin
        alu_func = ALU_PASS;
        alu_src1 = '0;
        alu_src2 = '0;
        case (state_q)
            ST_NEGA: begin
                alu_func = ALU_SUB;
                alu_src2 = a_q;
            end
            ST_NEGB: begin
                alu_func = ALU_SUB;
                alu_src2 = b_q;
            end
            ST_NEGR: begin
                alu_func = ALU_SUB;
                alu_src2 = res_q;
            end
            ST_ITER: begin
                if (op_is_div) begin
                    alu_func = ALU_SUB;
                    alu_src1 = s[XLEN-1:0];
                    alu_src2 = b_q;
                end else begin
                    alu_func = ALU_ADD;
                    alu_src1 = hi_q;
                    alu_src2 = lo_q[0] ? a_q : '0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        logic carry;
        logic need_neg;
        logic is_special;
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_d    = res_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        cnt_d    = cnt_q;
        carry    = (alu_out < hi_q);
        need_neg = 1'b0;
        is_special = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d = in_op;
                    a_d  = in_a;
                    b_d  = in_b;
                    sa_d = in_a[XLEN-1] & op_is_signed(in_op);
                    sb_d = in_b[XLEN-1] & op_is_signed(in_op);
                    is_special = in_op[2] && ((in_b == '0) ||
                                 (op_is_signed(in_op) && (in_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                                  (in_b == '1)));
                    if (op_is_illegal(in_op)) begin
                        res_d   = '0;
                        state_d = ST_DONE;
                    end else if (is_special) begin
                        state_d = ST_SPEC;
                    end else if (sa_d) begin
                        state_d = ST_NEGA;
                    end else if (sb_d) begin
                        state_d = ST_NEGB;
                    end else begin
                        state_d = ST_ITER;
                    end
                end
            end
            ST_SPEC: begin
                if (b_q == '0) begin
                    res_d = op_q[1] ? a_q : '1;
                end else begin
                    res_d = op_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                end
                state_d = ST_DONE;
            end
            ST_NEGA: begin
                a_d     = alu_out;
                state_d = sb_q ? ST_NEGB : ST_ITER;
            end
            ST_NEGB: begin
                b_d     = alu_out;
                state_d = ST_ITER;
            end
            ST_ITER: begin
                if (op_is_div) begin
                    hi_d = ge ? alu_out : s[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], ge};
                end else begin
                    hi_d = {carry, alu_out[XLEN-1:1]};
                    lo_d = {alu_out[0], lo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    res_d    = (op_is_div ? op_q[1] : op_q[0]) ? hi_d : lo_d;
                    need_neg = (op_q == OP_REM) ? sa_q :
                               (op_q == OP_DIV) ? (sa_q ^ sb_q) : 1'b0;
                    state_d  = need_neg ? ST_NEGR : ST_DONE;
                end
            end
            ST_NEGR: begin
                res_d   = alu_out;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // operands are final here, including any NEGA/NEGB rewrite this cycle
        if ((state_d == ST_ITER) && (state_q != ST_ITER)) begin
            hi_d  = '0;
            lo_d  = op_d[2] ? a_d : b_d;
            cnt_d = '1;
        end

        if (kill) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - randomized self-checking bench with a behavioural M-extension model
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        kill = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        busy;
    logic [31:0] alu_src1, alu_src2;
    logic [3:0]  alu_func;
    logic [31:0] alu_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign alu_out = (alu_func == 4'b0000) ? alu_src1 + alu_src2 :
                     (alu_func == 4'b0001) ? alu_src1 - alu_src2 : alu_src1;

    alu_muldiv_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .kill(kill),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .busy(busy), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_func(alu_func), .alu_out(alu_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        int   si, di;
        logic ovf;
        p   = {32'b0, a} * {32'b0, b};
        si  = a;
        di  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: return p[31:0];
            3'd1: return p[63:32];
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(si / di);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(si % di);
            3'd7: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit sgn, na, nb, nr;
        if (op == 3'd2 || op == 3'd3) return 1;
        sgn = (op == 3'd4) || (op == 3'd6);
        if (op[2] && (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
        na = sgn & a[31];
        nb = sgn & b[31];
        nr = (op == 3'd4) ? (na ^ nb) : (op == 3'd6) ? na : 1'b0;
        return 33 + int'(na) + int'(nb) + int'(nr);
    endfunction

    bit          m_busy = 1'b0;
    int          m_k = 0;
    int          m_lat = 0;
    logic [31:0] m_res = '0;
    logic [3:0]  m_func = 4'hF;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
        end else if (kill) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1'b1;
                m_k    = 1;
                m_res  = ref_result(in_op, in_a, in_b);
                m_lat  = ref_lat(in_op, in_a, in_b);
                m_func = (m_lat <= 2) ? 4'hF : in_op[2] ? 4'h1 : 4'h0;
            end
        end else if (m_k >= m_lat) begin
            if (out_ready) m_busy = 1'b0;
        end else begin
            m_k++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit         ov;
            logic [3:0] ef;
            ov = m_busy && (m_k >= m_lat);
            ef = (m_busy && m_k < m_lat) ? m_func : 4'hF;
            check("busy", 32'(busy), 32'(m_busy));
            check("in_ready", 32'(in_ready), 32'(!m_busy));
            check("out_valid", 32'(out_valid), 32'(ov));
            if (ov) check("out_result", out_result, m_res);
            check("alu_func", 32'(alu_func), 32'(ef));
            if (ef == 4'hF) begin
                check("alu_src1_idle", alu_src1, 32'h0);
                check("alu_src2_idle", alu_src2, 32'h0);
            end
        end
    end

    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int stall, input bit lit, input logic [31:0] lres, input int llat);
        int lat;
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op    = 3'($urandom);
        in_a     = $urandom;
        in_b     = $urandom;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check("result_arrives", 32'(out_valid), 32'h1);
        if (lit) begin
            check("model_pin", ref_result(op, a, b), lres);
            check("lit_result", out_result, lres);
            check("lit_latency", 32'(lat), 32'(llat));
        end
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1;
            if (lit) check("hold_in_ready", 32'(in_ready), 32'h0);
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic run_kill(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int k);
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = 1'($urandom);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (k) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill      = 1'b0;
        out_ready = 1'b1;
        check("kill_busy", 32'(busy), 32'h0);
        check("kill_out_valid", 32'(out_valid), 32'h0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_result", out_result, 32'h0);
        check("rst_alu_func", 32'(alu_func), 32'hF);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(3'd0, 32'h0000_FFFF, 32'h0001_0001, 0, 1, 32'hFFFF_FFFF, 33);
        run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFE, 33);
        run(3'd5, 32'd100, 32'd7, 0, 1, 32'd14, 33);
        run(3'd7, 32'd100, 32'd7, 0, 1, 32'd2, 33);
        run(3'd4, 32'hFFFF_FF9C, 32'd7, 0, 1, 32'hFFFF_FFF2, 35);
        run(3'd6, 32'hFFFF_FF9C, 32'd7, 0, 1, 32'hFFFF_FFFE, 35);
        run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 32'h8000_0000, 2);
        run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 32'h0, 2);
        run(3'd5, 32'd5, 32'd0, 0, 1, 32'hFFFF_FFFF, 2);
        run(3'd6, 32'hFFFF_FFF9, 32'd0, 0, 1, 32'hFFFF_FFF9, 2);
        run(3'd4, 32'd100, 32'hFFFF_FFF9, 0, 1, 32'hFFFF_FFF2, 35);
        run(3'd2, 32'd9, 32'd3, 0, 1, 32'h0, 1);
        run(3'd0, 32'd1234, 32'd5678, 10, 1, 32'd7006652, 33);
        run(3'd5, 32'd1000, 32'd10, 0, 1, 32'd100, 33);

        run_kill(3'd5, 32'd100, 32'd7, 16);
        in_valid = 1'b1;
        kill     = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        kill     = 1'b0;
        check("kill_idle_no_accept", 32'(busy), 32'h0);

        in_valid = 1'b1;
        in_op    = 3'd0;
        in_a     = 32'd3;
        in_b     = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_in_ready", 32'(in_ready), 32'h1);
        check("midrst_out_valid", 32'(out_valid), 32'h0);
        check("midrst_out_result", out_result, 32'h0);
        check("midrst_alu_func", 32'(alu_func), 32'hF);
        check("midrst_alu_src1", alu_src1, 32'h0);

        for (int i = 0; i < 150; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            if ($urandom_range(0, 9) == 0) run_kill(op, a, b, $urandom_range(0, 40));
            else run(op, a, b, $urandom_range(0, 3), 0, 32'h0, 0);
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
